jtag_instr_dcd: RTL and testbench
=================================

Name: jtag_instr_dcd

Overview: Function-code decoder for the USER1 JTAG chain, directly upstream of the per-function user capture/shift registers. It shifts in a W-bit function code on USER1 and latches it on Update-DR. It decodes the code into one-hot function-select lines, which feed the FSH/FCAP inputs of the USER2 capture registers. It also produces a one-cycle soft-reset pulse, an illegal-code flag and a valid-update counter for status readback.

Parameters:
W, 8, function code width in bits
NFUNC, 32, number of one-hot function outputs (2..2^W); codes 1..NFUNC-1 are valid functions
RST_CODE, 8'hFF, code that produces SOFT_RST; must be >= NFUNC

Ports:
DRCK  input  1  JTAG data-register clock from the BSCAN primitive; all state on rising edge
RST  input  1  asynchronous reset, active-high
SEL1  input  1  USER1 instruction selected
TDI  input  1  serial data in
SHIFT  input  1  Shift-DR state, level
CAPTURE  input  1  Capture-DR state, level
UPDATE  input  1  Update-DR state, level, sampled on DRCK rising edge
TDO1  output  1  serial out to the USER1 TDO mux
F  output  NFUNC  one-hot function selects, registered; F[0] is never asserted (code 0 = NOP)
INSTR  output  W  currently latched function code
ILLEGAL  output  1  last update carried an out-of-range code
SOFT_RST  output  1  one-DRCK-cycle pulse on a RST_CODE update
UPD_CNT  output  8  count of valid updates, saturating

Behaviour:
- Reset (asynchronous, RST=1): sr=0, INSTR=0, F=0, ILLEGAL=0, SOFT_RST=0, UPD_CNT=0. While RST is high all outputs hold these values and DRCK edges are ignored.
- All actions are gated by SEL1. With SEL1=0, sr, INSTR and F hold, and SOFT_RST returns to 0 on the next edge.
- Priority when SEL1=1 and several controls are high on the same edge: UPDATE > CAPTURE > SHIFT.
- SHIFT: sr <= {TDI, sr[W-1:1]}. This is a right shift, LSB exits first, matching the downstream capture registers.
- CAPTURE: sr <= INSTR, so the next W shifts read back the current code on TDO1.
- TDO1 = SEL1 & sr[0], combinational.
- UPDATE (the edge where SEL1 & UPDATE are sampled high). Let c = sr:
  - 1 <= c < NFUNC: INSTR<=c; F<=one-hot(c); ILLEGAL<=0; UPD_CNT<=UPD_CNT+1, saturating at 255.
  - c == 0: INSTR<=0; F<=0; ILLEGAL<=0; UPD_CNT increments (NOP counts as valid).
  - c == RST_CODE: SOFT_RST<=1 for exactly one cycle; INSTR<=0; F<=0; ILLEGAL<=0; UPD_CNT<=0.
  - any other c >= NFUNC: INSTR<=c; F<=0; ILLEGAL<=1; UPD_CNT unchanged.
- Output latency: F, INSTR and ILLEGAL are valid after the UPDATE edge and hold until the next UPDATE or reset. There are no glitches, because F is a register and not decoded combinationally from INSTR.
- UPDATE held high for multiple edges: each edge re-evaluates sr.
  - sr is unchanged, so F and INSTR are stable.
  - UPD_CNT increments once per edge. Test benches must use single-cycle UPDATE.
  - SOFT_RST: if UPDATE with RST_CODE persists, SOFT_RST stays high for each such edge. Otherwise it clears the edge after it was set.
- Shift counts other than W: the last W bits shifted in win; no error is flagged.
- Reset mid-shift: sr clears immediately and the partially shifted code is lost. F drops asynchronously, deasserting every downstream select.
- F is one-hot or all-zero at every clock edge.

Test Plan:
- Reset release → TDO1=0, F=0, INSTR=0, ILLEGAL=0, UPD_CNT=0, SOFT_RST=0.
- SEL1=1, shift 8'h05 LSB first (1,0,1,0,0,0,0,0), then one UPDATE edge → next cycle F=32'h0000_0020, INSTR=8'h05, UPD_CNT=1. Then CAPTURE + 8 shifts → TDO1 sequence 1,0,1,0,0,0,0,0.
- Shift 8'h40 (>= NFUNC, not RST_CODE) + UPDATE → F=0, INSTR=8'h40, ILLEGAL=1, UPD_CNT unchanged. Then shift 8'h03 + UPDATE → F=32'h8, ILLEGAL=0.
- With UPD_CNT=3, shift 8'hFF + UPDATE → SOFT_RST high for exactly one DRCK cycle, F=0, INSTR=0, UPD_CNT=0.
- SEL1=0 while SHIFT/UPDATE toggle with TDI=1 → sr, F and INSTR unchanged; TDO1=0.
- Assert RST mid-shift after 4 bits with F=32'h20 → F=0 asynchronously, before the next DRCK edge. Release RST, full 8-bit shift of 8'h02 + UPDATE → F=32'h4, UPD_CNT=1.

Source files
------------

// File: rtl/jtag_instr_dcd.sv
// USER1 function-code decoder: shifts in a code, latches it on Update-DR,
// and drives registered one-hot selects, soft-reset pulse and status.
module jtag_instr_dcd #(
  parameter int             W        = 8,
  parameter int             NFUNC    = 32,
  parameter logic [W-1:0]   RST_CODE = 8'hFF
) (
  input  logic             DRCK,
  input  logic             RST,
  input  logic             SEL1,
  input  logic             TDI,
  input  logic             SHIFT,
  input  logic             CAPTURE,
  input  logic             UPDATE,
  output logic             TDO1,
  output logic [NFUNC-1:0] F,
  output logic [W-1:0]     INSTR,
  output logic             ILLEGAL,
  output logic             SOFT_RST,
  output logic [7:0]       UPD_CNT
);

  localparam logic [W:0] NF = NFUNC[W:0];

  logic [W-1:0]     sr;
  logic [NFUNC-1:0] onehot;
  logic             is_rst;
  logic             is_valid;

  assign is_rst   = (sr == RST_CODE);
  assign is_valid = ({1'b0, sr} < NF);
  assign TDO1     = SEL1 & sr[0];

  // bit 0 stays low so code 0 decodes to an all-zero NOP
  always_comb begin
    onehot = '0;
    for (int i = 1; i < NFUNC; i++) begin
      onehot[i] = (sr == W'(i));
    end
  end

  always_ff @(posedge DRCK or posedge RST) begin
    if (RST) begin
      sr       <= '0;
      INSTR    <= '0;
      F        <= '0;
      ILLEGAL  <= 1'b0;
      SOFT_RST <= 1'b0;
      UPD_CNT  <= '0;
    end else begin
      SOFT_RST <= 1'b0;
      if (SEL1) begin
        if (UPDATE) begin
          if (is_rst) begin
            SOFT_RST <= 1'b1;
            INSTR    <= '0;
            F        <= '0;
            ILLEGAL  <= 1'b0;
            UPD_CNT  <= '0;
          end else if (is_valid) begin
            INSTR   <= sr;
            F       <= onehot;
            ILLEGAL <= 1'b0;
            if (UPD_CNT != 8'hFF) begin
              UPD_CNT <= UPD_CNT + 8'd1;
            end
          end else begin
            INSTR   <= sr;
            F       <= '0;
            ILLEGAL <= 1'b1;
          end
        end else if (CAPTURE) begin
          sr <= INSTR;
        end else if (SHIFT) begin
          sr <= {TDI, sr[W-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_instr_dcd.sv
// Directed self-checking bench for the USER1 function-code decoder.
module tb_jtag_instr_dcd;

  logic        DRCK = 1'b0;
  logic        RST, SEL1, TDI, SHIFT, CAPTURE, UPDATE;
  logic        TDO1;
  logic [31:0] F;
  logic [7:0]  INSTR;
  logic        ILLEGAL, SOFT_RST;
  logic [7:0]  UPD_CNT;

  int checks = 0;
  int errors = 0;

  jtag_instr_dcd dut (
    .DRCK(DRCK), .RST(RST), .SEL1(SEL1), .TDI(TDI),
    .SHIFT(SHIFT), .CAPTURE(CAPTURE), .UPDATE(UPDATE),
    .TDO1(TDO1), .F(F), .INSTR(INSTR), .ILLEGAL(ILLEGAL),
    .SOFT_RST(SOFT_RST), .UPD_CNT(UPD_CNT)
  );

  always #5 DRCK = ~DRCK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge DRCK);
    #1;
  endtask

  task automatic shift_code(input logic [7:0] c);
    SHIFT = 1'b1;
    for (int i = 0; i < 8; i++) begin
      TDI = c[i];
      step();
    end
    SHIFT = 1'b0;
    TDI   = 1'b0;
  endtask

  task automatic update();
    UPDATE = 1'b1;
    step();
    UPDATE = 1'b0;
  endtask

  task automatic read_out(input string tag, input logic [7:0] c);
    SHIFT = 1'b1;
    TDI   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk(tag, 32'(TDO1), 32'(c[i]));
      step();
    end
    SHIFT = 1'b0;
  endtask

  initial begin
    RST = 1'b1; SEL1 = 1'b0; TDI = 1'b0;
    SHIFT = 1'b0; CAPTURE = 1'b0; UPDATE = 1'b0;
    #23;
    RST = 1'b0;
    step();
    chk("rst_tdo", 32'(TDO1), 32'd0);
    chk("rst_f", F, 32'h0);
    chk("rst_instr", 32'(INSTR), 32'h0);
    chk("rst_ill", 32'(ILLEGAL), 32'd0);
    chk("rst_cnt", 32'(UPD_CNT), 32'd0);
    chk("rst_srst", 32'(SOFT_RST), 32'd0);

    SEL1 = 1'b1;
    shift_code(8'h05);
    update();
    chk("c05_f", F, 32'h0000_0020);
    chk("c05_instr", 32'(INSTR), 32'h05);
    chk("c05_cnt", 32'(UPD_CNT), 32'd1);
    chk("c05_ill", 32'(ILLEGAL), 32'd0);

    CAPTURE = 1'b1;
    step();
    CAPTURE = 1'b0;
    read_out("cap05_tdo", 8'h05);

    shift_code(8'h40);
    update();
    chk("c40_f", F, 32'h0);
    chk("c40_instr", 32'(INSTR), 32'h40);
    chk("c40_ill", 32'(ILLEGAL), 32'd1);
    chk("c40_cnt", 32'(UPD_CNT), 32'd1);

    shift_code(8'h03);
    update();
    chk("c03_f", F, 32'h8);
    chk("c03_ill", 32'(ILLEGAL), 32'd0);
    chk("c03_cnt", 32'(UPD_CNT), 32'd2);

    shift_code(8'h01);
    update();
    chk("c01_f", F, 32'h2);
    chk("c01_cnt", 32'(UPD_CNT), 32'd3);

    shift_code(8'hFF);
    chk("shift_hold_f", F, 32'h2);
    update();
    chk("cff_srst", 32'(SOFT_RST), 32'd1);
    chk("cff_f", F, 32'h0);
    chk("cff_instr", 32'(INSTR), 32'h0);
    chk("cff_cnt", 32'(UPD_CNT), 32'd0);
    chk("cff_ill", 32'(ILLEGAL), 32'd0);
    step();
    chk("cff_srst_clr", 32'(SOFT_RST), 32'd0);

    shift_code(8'h05);
    update();
    chk("re05_f", F, 32'h20);
    chk("re05_cnt", 32'(UPD_CNT), 32'd1);

    SEL1 = 1'b0;
    TDI  = 1'b1;
    SHIFT = 1'b1;
    step();
    chk("nosel_tdo", 32'(TDO1), 32'd0);
    step();
    SHIFT  = 1'b0;
    UPDATE = 1'b1;
    step();
    UPDATE = 1'b0;
    TDI    = 1'b0;
    chk("nosel_f", F, 32'h20);
    chk("nosel_instr", 32'(INSTR), 32'h05);
    chk("nosel_cnt", 32'(UPD_CNT), 32'd1);
    SEL1 = 1'b1;
    #1;
    read_out("nosel_sr", 8'h05);

    shift_code(8'h03);
    SHIFT = 1'b1; TDI = 1'b1; UPDATE = 1'b1;
    step();
    SHIFT = 1'b0; TDI = 1'b0; UPDATE = 1'b0;
    chk("prio_f", F, 32'h8);
    chk("prio_cnt", 32'(UPD_CNT), 32'd2);
    read_out("prio_sr", 8'h03);

    shift_code(8'h04);
    UPDATE = 1'b1;
    for (int i = 0; i < 260; i++) step();
    UPDATE = 1'b0;
    chk("sat_cnt", 32'(UPD_CNT), 32'd255);
    chk("sat_f", F, 32'h10);

    shift_code(8'h05);
    update();
    chk("pre_rst_f", F, 32'h20);
    chk("pre_rst_cnt", 32'(UPD_CNT), 32'd255);
    SHIFT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      TDI = 1'b1;
      step();
    end
    #2;
    RST = 1'b1;
    #1;
    chk("async_f", F, 32'h0);
    chk("async_instr", 32'(INSTR), 32'h0);
    chk("async_cnt", 32'(UPD_CNT), 32'd0);
    chk("async_tdo", 32'(TDO1), 32'd0);
    SHIFT = 1'b0;
    TDI   = 1'b0;
    #2;
    RST = 1'b0;
    shift_code(8'h02);
    update();
    chk("post_rst_f", F, 32'h4);
    chk("post_rst_cnt", 32'(UPD_CNT), 32'd1);
    chk("post_rst_instr", 32'(INSTR), 32'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
